alu_md: RTL and testbench

Parametrised, clocked ALU for the MIPS datapath. It adds a multi-cycle unsigned multiply/divide unit with HI/LO registers and a start/busy/done handshake. Single-cycle logic and arithmetic ops produce a registered result one cycle after acceptance. MULTU/DIVU iterate one bit per cycle. The control unit stalls the pipeline while `busy` is high.

---
 rtl/alu_md.sv | 194 +++++++++++++++++++
 tb/tb_alu_md.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
// Clocked MIPS ALU with an iterative unsigned multiply/divide unit and HI/LO registers.
// Optional divider datapath is built when ALU_MD_DIV_EN is defined.
module alu_md #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alu_cs,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ZERO,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_SLT   = 3'b100;
    localparam logic [2:0] OP_MULTU = 3'b101;
    localparam logic [2:0] OP_DIVU  = 3'b110;
    localparam logic [2:0] OP_NOR   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            done_nxt;
    logic [WIDTH-1:0] result_nxt, hi_nxt, lo_nxt;

    // Shared iteration registers: MUL uses {acc_hi,acc_lo} as the product and opnd as
    // the multiplicand; DIV uses acc_hi as remainder, acc_lo as dividend/quotient.
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic [WIDTH-1:0] acc_hi_nxt, acc_lo_nxt, opnd_nxt;

    function automatic logic slt_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        sa = a;
        sb = b;
        return (sa < sb);
    endfunction

    function automatic logic [WIDTH-1:0] alu_f(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLT:  r = {{(WIDTH-1){1'b0}}, slt_f(a, b)};
            OP_NOR:  r = ~(a | b);
            OP_MULTU, OP_DIVU: r = '0;
            default: r = '0;
        endcase
        return r;
    endfunction

    // One shift-add step: conditionally add the multiplicand, then shift the product right.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_step, mul_lo_step;

    always_comb begin
        mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        mul_hi_step = mul_sum[WIDTH:1];
        mul_lo_step = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end

`ifdef ALU_MD_DIV_EN
    // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem_step, div_quo_step;

    always_comb begin
        div_sh       = {acc_hi, acc_lo[WIDTH-1]};
        div_ge       = (div_sh >= {1'b0, opnd});
        div_rem_step = div_ge ? (div_sh[WIDTH-1:0] - opnd) : div_sh[WIDTH-1:0];
        div_quo_step = {acc_lo[WIDTH-2:0], div_ge};
    end
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        done_nxt   = 1'b0;
        result_nxt = result;
        hi_nxt     = hi;
        lo_nxt     = lo;
        acc_hi_nxt = acc_hi;
        acc_lo_nxt = acc_lo;
        opnd_nxt   = opnd;

        case (state)
            IDLE: begin
                if (start) begin
                    case (alu_cs)
                        OP_MULTU: begin
                            state_nxt  = MUL;
                            cnt_nxt    = '0;
                            acc_hi_nxt = '0;
                            acc_lo_nxt = B;
                            opnd_nxt   = A;
                        end
`ifdef ALU_MD_DIV_EN
                        OP_DIVU: begin
                            state_nxt  = DIV;
                            cnt_nxt    = '0;
                            acc_hi_nxt = '0;
                            acc_lo_nxt = A;
                            opnd_nxt   = B;
                        end
`endif
                        default: begin
                            result_nxt = alu_f(alu_cs, A, B);
                            done_nxt   = 1'b1;
                        end
                    endcase
                end
            end
            MUL: begin
                acc_hi_nxt = mul_hi_step;
                acc_lo_nxt = mul_lo_step;
                cnt_nxt    = cnt + 1'b1;
                if (cnt == LAST_ITER) begin
                    state_nxt  = IDLE;
                    hi_nxt     = mul_hi_step;
                    lo_nxt     = mul_lo_step;
                    result_nxt = mul_lo_step;
                    done_nxt   = 1'b1;
                end
            end
`ifdef ALU_MD_DIV_EN
            DIV: begin
                acc_hi_nxt = div_rem_step;
                acc_lo_nxt = div_quo_step;
                cnt_nxt    = cnt + 1'b1;
                if (cnt == LAST_ITER) begin
                    state_nxt  = IDLE;
                    hi_nxt     = div_rem_step;
                    lo_nxt     = div_quo_step;
                    result_nxt = div_quo_step;
                    done_nxt   = 1'b1;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            done   <= 1'b0;
            result <= '0;
            ZERO   <= 1'b1;
            hi     <= '0;
            lo     <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            done   <= done_nxt;
            result <= result_nxt;
            ZERO   <= (result_nxt == '0);
            hi     <= hi_nxt;
            lo     <= lo_nxt;
        end
    end

    // Iteration scratch registers are only meaningful while busy, so they carry no reset.
    always_ff @(posedge clk) begin
        acc_hi <= acc_hi_nxt;
        acc_lo <= acc_lo_nxt;
        opnd   <= opnd_nxt;
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md at WIDTH=32.
module tb_alu_md;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  alu_cs;
    logic [31:0] A, B;
    logic        busy, done, ZERO;
    logic [31:0] result, hi, lo;

    int checks = 0;
    int errors = 0;

    alu_md #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .alu_cs(alu_cs), .A(A), .B(B),
        .busy(busy), .done(done), .result(result), .ZERO(ZERO), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic single(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        alu_cs = op; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".result"}, result, exp);
        chk({tag, ".zero"}, 32'(ZERO), 32'(exp == 32'd0));
    endtask

    task automatic md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ehi, input logic [31:0] elo, input bit inj,
                      input string tag);
        int lat;
        int bc;
        alu_cs = op; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        bc = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            if (inj && lat == 10) begin
                alu_cs = 3'b010; A = 32'd3; B = 32'd4; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk({tag, ".latency"}, 32'(lat), 32'd32);
        chk({tag, ".busy_cycles"}, 32'(bc), 32'd32);
        chk({tag, ".busy_end"}, 32'(busy), 32'd0);
        chk({tag, ".hi"}, hi, ehi);
        chk({tag, ".lo"}, lo, elo);
        chk({tag, ".result"}, result, elo);
        chk({tag, ".zero"}, 32'(ZERO), 32'(elo == 32'd0));
    endtask

    initial begin
        int lat;
        int dcnt;
        reset = 1'b1; start = 1'b0; alu_cs = 3'b000; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.result", result, 32'd0);
        chk("rst.zero", 32'(ZERO), 32'd1);
        chk("rst.hi", hi, 32'd0);
        chk("rst.lo", lo, 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Back-to-back single-cycle ops, one per clock.
        single(3'b000, 32'd30, 32'd25, 32'd24, "and");
        single(3'b001, 32'd30, 32'd25, 32'd31, "or");
        single(3'b010, 32'd30, 32'd25, 32'd55, "add");
        single(3'b011, 32'd30, 32'd25, 32'd5, "sub");
        single(3'b100, 32'd30, 32'd25, 32'd0, "slt");
        single(3'b111, 32'd30, 32'd25, 32'hFFFF_FFE0, "nor");
        single(3'b010, 32'hFFFF_FFFF, 32'd1, 32'd0, "add_wrap");
        single(3'b100, 32'hFFFF_FFFF, 32'd1, 32'd1, "slt_neg");
        single(3'b100, 32'd1, 32'hFFFF_FFFF, 32'd0, "slt_pos");
        @(posedge clk); #1;
        chk("idle.done", 32'(done), 32'd0);
        chk("idle.result_hold", result, 32'd0);
        chk("idle.zero_hold", 32'(ZERO), 32'd1);
        chk("single.hi_kept", hi, 32'd0);

        md(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "mul_max");
        @(posedge clk); #1;
        chk("mul.done_pulse", 32'(done), 32'd0);

`ifdef ALU_MD_DIV_EN
        md(3'b110, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "div");
        md(3'b110, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0, "div0");
`else
        single(3'b110, 32'd100, 32'd7, 32'd0, "divu_off");
        chk("divu_off.hi", hi, 32'hFFFF_FFFE);
        chk("divu_off.lo", lo, 32'h0000_0001);
`endif

        md(3'b101, 32'd0, 32'd7, 32'd0, 32'd0, 1'b0, "mul_zero");

        // Start during busy is ignored; start during the done cycle is accepted.
        md(3'b101, 32'd6, 32'd7, 32'd0, 32'd42, 1'b1, "mul_inj");
        single(3'b010, 32'd3, 32'd4, 32'd7, "add_after_done");

        md(3'b101, 32'd5769, 32'd6700417, 32'd9, 32'd9, 1'b0, "mul_nine");

        // Reset in the middle of MULTU 6x7.
        alu_cs = 3'b101; A = 32'd6; B = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("mid.busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mid.busy", 32'(busy), 32'd0);
        chk("mid.hi", hi, 32'd0);
        chk("mid.lo", lo, 32'd0);
        chk("mid.result", result, 32'd0);
        chk("mid.zero", 32'(ZERO), 32'd1);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dcnt++;
            @(posedge clk); #1;
        end
        chk("mid.no_done", 32'(dcnt), 32'd0);
        chk("mid.lo_after", lo, 32'd0);

        single(3'b011, 32'd10, 32'd3, 32'd7, "sub_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
